// File: rtl/dag_addr_gen.sv
// rtl/dag_addr_gen.sv - data address generator with I/M/L/B register file and circular wrap
module dag_addr_gen #(
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input  logic          clk_exe,
  input  logic          rst,
  input  logic          ps_dg_en,
  input  logic          ps_dg_dgsclt,
  input  logic          ps_dg_mdfy,
  input  logic [2:0]    ps_dg_iadd,
  input  logic [2:0]    ps_dg_madd,
  input  logic [DW-1:0] ps_dg_immdt,
  input  logic [4:0]    ps_dg_rd_add,
  input  logic [4:0]    ps_dg_wrt_add,
  input  logic          ps_dg_wrt_en,
  input  logic [DW-1:0] bc_dg_dt,
  output logic [DW-1:0] dg_ps_add,
  output logic          dg_add_vld,
  output logic [DW-1:0] dg_bc_dt
);

  localparam logic [1:0] GRP_I = 2'b00;
  localparam logic [1:0] GRP_M = 2'b01;
  localparam logic [1:0] GRP_L = 2'b10;
  localparam logic [1:0] GRP_B = 2'b11;

  logic [DW-1:0] i_reg [NREG];
  logic [DW-1:0] m_reg [NREG];
  logic [DW-1:0] l_reg [NREG];
  logic [DW-1:0] b_reg [NREG];

  logic [DW-1:0] mod_val;
  logic [DW-1:0] cur_i;
  logic [DW-1:0] cur_b;
  logic [DW-1:0] cur_l;
  logic [DW:0]   sum;
  logic [DW:0]   buf_end;
  logic [DW:0]   wrapped;
  logic [DW-1:0] next_addr;

  always_comb begin
    mod_val = ps_dg_dgsclt ? ps_dg_immdt : m_reg[ps_dg_madd];
    cur_i   = i_reg[ps_dg_iadd];
    cur_b   = b_reg[ps_dg_iadd];
    cur_l   = l_reg[ps_dg_iadd];
    sum     = {1'b0, cur_i} + {mod_val[DW-1], mod_val};
    buf_end = {1'b0, cur_b} + {1'b0, cur_l};
    wrapped = sum;
    // A zero length register means plain linear addressing
    if (cur_l != '0) begin
      if (sum >= buf_end) begin
        wrapped = sum - {1'b0, cur_l};
      end else if (sum < {1'b0, cur_b}) begin
        wrapped = sum + {1'b0, cur_l};
      end
    end
    next_addr = wrapped[DW-1:0];
  end

  always_ff @(posedge clk_exe or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++) begin
        i_reg[k] <= '0;
        m_reg[k] <= '0;
        l_reg[k] <= '0;
        b_reg[k] <= '0;
      end
      dg_ps_add  <= '0;
      dg_add_vld <= 1'b0;
    end else begin
      dg_add_vld <= ps_dg_en;
      if (ps_dg_en) begin
        dg_ps_add <= ps_dg_mdfy ? next_addr : cur_i;
        if (!ps_dg_mdfy) begin
          i_reg[ps_dg_iadd] <= next_addr;
        end
      end
      // Placed after the post-modify so a same-edge ureg write to I wins
      if (ps_dg_wrt_en) begin
        case (ps_dg_wrt_add[4:3])
          GRP_I: i_reg[ps_dg_wrt_add[2:0]] <= bc_dg_dt;
          GRP_M: m_reg[ps_dg_wrt_add[2:0]] <= bc_dg_dt;
          GRP_L: l_reg[ps_dg_wrt_add[2:0]] <= bc_dg_dt;
          GRP_B: begin
            b_reg[ps_dg_wrt_add[2:0]] <= bc_dg_dt;
            i_reg[ps_dg_wrt_add[2:0]] <= bc_dg_dt;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    dg_bc_dt = '0;
    case (ps_dg_rd_add[4:3])
      GRP_I:   dg_bc_dt = i_reg[ps_dg_rd_add[2:0]];
      GRP_M:   dg_bc_dt = m_reg[ps_dg_rd_add[2:0]];
      GRP_L:   dg_bc_dt = l_reg[ps_dg_rd_add[2:0]];
      GRP_B:   dg_bc_dt = b_reg[ps_dg_rd_add[2:0]];
      default: dg_bc_dt = '0;
    endcase
  end

endmodule
